cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Consumer end of the ALU flag interface: latches the 4-bit {N,Z,C,V} flag vector, evaluates each instruction's 4-bit ARM condition field against the stored flags, and gates that instruction's side effects (branch, register write, memory write).
- Sits in the execute stage between the main decoder and the ALU.
- Produces registered, condition-qualified control strobes one cycle later for the memory/writeback stage.

Parameters:
- CNT_W, 16, width of the saturating condition-failed instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- en_i  input  1  valid instruction in execute this cycle
- stall_i  input  1  hold pipeline; no state update except counter hold
- flush_i  input  1  kill the current execute instruction
- cond_i  input  4  instruction condition field, ARM encoding
- aluflags_i  input  4  {N,Z,C,V} from ALU for the current instruction
- flagw_i  input  2  [1] write N,Z; [0] write C,V
- pcs_i  input  1  decoded PC-source request
- regw_i  input  1  decoded register-write request
- memw_i  input  1  decoded memory-write request
- nowrite_i  input  1  compare-type instruction; suppress register write
- flags_o  output  4  stored {N,Z,C,V}
- condex_o  output  1  combinational condition pass for the current execute instruction
- valid_o  output  1  registered: instruction accepted last edge
- pcsrc_o  output  1  registered gated pcs
- regwrite_o  output  1  registered gated regw
- memwrite_o  output  1  registered gated memw
- illegal_o  output  1  registered: cond_i==4'b1111 seen on an accepted instruction
- failcnt_o  output  CNT_W  count of accepted instructions whose condition failed

Behaviour:
- Reset (async, reset_n=0): flags_o=0; valid_o, pcsrc_o, regwrite_o, memwrite_o and illegal_o = 0; failcnt_o=0. Reset mid-stream discards any in-flight strobe immediately (no clock needed).
- Condition decode uses flags_o (stored), never aluflags_i:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111: condex=0, flagged illegal.
- condex_o is purely combinational from cond_i and flags_o and ignores en_i.
- accept = en_i & !stall_i & !flush_i.
- Flag update at the rising edge, only when accept & condex:
  - flagw_i[1] loads N,Z from aluflags_i[3:2].
  - flagw_i[0] loads C,V from aluflags_i[1:0].
  - Each half is independent.
- Output register:
  - stall_i=1 (wins over flush_i): hold all outputs and the counter.
  - Otherwise valid_o<=accept.
  - pcsrc_o<=accept&condex&pcs_i.
  - regwrite_o<=accept&condex&regw_i&!nowrite_i.
  - memwrite_o<=accept&condex&memw_i.
  - illegal_o<=accept&(cond_i==4'hF).
- Latency: strobes appear exactly 1 cycle after acceptance; flags visible to the next instruction's condition on the following cycle (back-to-back CMP then BEQ works with no bubble).
- Flush with en_i=1: no flag update, strobes 0, valid_o=0, counter unchanged.
- Counter: on accept & !condex, failcnt_o increments and saturates at all-ones (no wrap). cond 1111 counts as failed.

Optional Feature:
- Macro: COND_LOGIC_FLAG_SAVE_EN.
- When defined, add these ports:
  - save_i (input 1)
  - restore_i (input 1)
  - saved_flags_o (output 4, reset 0)
- save_i copies flags_o into saved_flags_o at the edge.
- restore_i loads flags_o from saved_flags_o at the edge; restore overrides any same-cycle flagw update.
- Both save_i and restore_i asserted: swap the two registers.
- Both are honoured even during stall_i.
- When not defined: ports absent, no saved register, behaviour otherwise identical.

Test Plan:
- Reset, then en_i=1, cond=1110, aluflags=4'b0100, flagw=2'b11 -> next cycle flags_o=4'b0100; following instruction cond=0000 gives condex_o=1.
- Back-to-back: CMP (flagw=11, aluflags Z=1, nowrite=1, regw=1) then BEQ (cond=0000, pcs=1) -> CMP regwrite_o=0; BEQ pcsrc_o=1 exactly one cycle after it is accepted.
- flags_o=4'b1001 (N=1,V=1): GE, LT, GT -> condex 1, 0, 1; flags 4'b0010 for HI -> 1; 4'b0110 for HI -> 0.
- Partial write: flags_o=4'b1111, flagw=2'b01, aluflags=4'b0000 -> flags_o=4'b1100.
- stall_i=1 with en_i=1, flagw=11 -> flags and outputs frozen; flush_i=1 -> valid_o=0, strobes 0, no flag change; reset_n low mid-cycle -> outputs 0 immediately.
- With CNT_W=2: five accepted failing instructions -> failcnt_o 1,2,3,3,3; cond=1111 accepted -> illegal_o=1 next cycle, memwrite_o=0.

Source files
------------

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// cond_logic : ARM condition-code evaluation, {N,Z,C,V} flag store and
// condition-gated branch/register/memory strobes for the writeback stage.
// Optional macro COND_LOGIC_FLAG_SAVE_EN adds a flag save/restore register.
// Revision 1.0
// ============================================================================
module cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [3:0]       cond_i,
   input  logic [3:0]       aluflags_i,
   input  logic [1:0]       flagw_i,
   input  logic             pcs_i,
   input  logic             regw_i,
   input  logic             memw_i,
   input  logic             nowrite_i,
`ifdef COND_LOGIC_FLAG_SAVE_EN
   input  logic             save_i,
   input  logic             restore_i,
   output logic [3:0]       saved_flags_o,
`endif
   output logic [3:0]       flags_o,
   output logic             condex_o,
   output logic             valid_o,
   output logic             pcsrc_o,
   output logic             regwrite_o,
   output logic             memwrite_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] failcnt_o
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       flags_q, flags_d;
   logic             valid_q, valid_d;
   logic             pcsrc_q, pcsrc_d;
   logic             regw_q, regw_d;
   logic             memw_q, memw_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_condex;
   logic             w_accept;
   logic             w_n, w_z, w_c, w_v;

   assign {w_n, w_z, w_c, w_v} = flags_q;
   assign w_accept = en_i & ~stall_i & ~flush_i;

   // Evaluated against the stored flags only, so a flag-setting instruction
   // affects the condition of the instruction that follows it.
   always_comb begin
      w_condex = 1'b0;
      case (cond_i)
         4'h0: w_condex = w_z;
         4'h1: w_condex = ~w_z;
         4'h2: w_condex = w_c;
         4'h3: w_condex = ~w_c;
         4'h4: w_condex = w_n;
         4'h5: w_condex = ~w_n;
         4'h6: w_condex = w_v;
         4'h7: w_condex = ~w_v;
         4'h8: w_condex = w_c & ~w_z;
         4'h9: w_condex = ~w_c | w_z;
         4'hA: w_condex = (w_n == w_v);
         4'hB: w_condex = (w_n != w_v);
         4'hC: w_condex = ~w_z & (w_n == w_v);
         4'hD: w_condex = w_z | (w_n != w_v);
         4'hE: w_condex = 1'b1;
         default: w_condex = 1'b0;
      endcase
   end

`ifdef COND_LOGIC_FLAG_SAVE_EN
   logic [3:0] saved_q, saved_d;
`endif

   always_comb begin
      flags_d = flags_q;
      if (w_accept && w_condex) begin
         if (flagw_i[1]) flags_d[3:2] = aluflags_i[3:2];
         if (flagw_i[0]) flags_d[1:0] = aluflags_i[1:0];
      end
`ifdef COND_LOGIC_FLAG_SAVE_EN
      // Save and restore together swap the two registers.
      saved_d = save_i ? flags_q : saved_q;
      if (restore_i) flags_d = saved_q;
`endif
   end

   always_comb begin
      valid_d = valid_q;
      pcsrc_d = pcsrc_q;
      regw_d  = regw_q;
      memw_d  = memw_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q;
      if (!stall_i) begin
         valid_d = w_accept;
         pcsrc_d = w_accept & w_condex & pcs_i;
         regw_d  = w_accept & w_condex & regw_i & ~nowrite_i;
         memw_d  = w_accept & w_condex & memw_i;
         ill_d   = w_accept & (cond_i == 4'hF);
      end
      if (w_accept && !w_condex && !(&cnt_q)) cnt_d = cnt_q + c_CNT_ONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= 4'h0;
         valid_q <= 1'b0;
         pcsrc_q <= 1'b0;
         regw_q  <= 1'b0;
         memw_q  <= 1'b0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         flags_q <= flags_d;
         valid_q <= valid_d;
         pcsrc_q <= pcsrc_d;
         regw_q  <= regw_d;
         memw_q  <= memw_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef COND_LOGIC_FLAG_SAVE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) saved_q <= 4'h0;
      else          saved_q <= saved_d;
   end
   assign saved_flags_o = saved_q;
`endif

   assign flags_o    = flags_q;
   assign condex_o   = w_condex;
   assign valid_o    = valid_q;
   assign pcsrc_o    = pcsrc_q;
   assign regwrite_o = regw_q;
   assign memwrite_o = memw_q;
   assign illegal_o  = ill_q;
   assign failcnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// Table-driven bench for cond_logic with a scoreboard of registered outputs.
module tb_cond_logic;

   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          en_i, stall_i, flush_i;
   logic [3:0]    cond_i, aluflags_i;
   logic [1:0]    flagw_i;
   logic          pcs_i, regw_i, memw_i, nowrite_i;
   logic [3:0]    flags_o;
   logic          condex_o, valid_o, pcsrc_o, regwrite_o, memwrite_o, illegal_o;
   logic [CW-1:0] failcnt_o;
`ifdef COND_LOGIC_FLAG_SAVE_EN
   logic          save_i = 1'b0;
   logic          restore_i = 1'b0;
   logic [3:0]    saved_flags_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cond_logic #(.CNT_W(CW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en_i       (en_i),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .cond_i     (cond_i),
      .aluflags_i (aluflags_i),
      .flagw_i    (flagw_i),
      .pcs_i      (pcs_i),
      .regw_i     (regw_i),
      .memw_i     (memw_i),
      .nowrite_i  (nowrite_i),
`ifdef COND_LOGIC_FLAG_SAVE_EN
      .save_i     (save_i),
      .restore_i  (restore_i),
      .saved_flags_o(saved_flags_o),
`endif
      .flags_o    (flags_o),
      .condex_o   (condex_o),
      .valid_o    (valid_o),
      .pcsrc_o    (pcsrc_o),
      .regwrite_o (regwrite_o),
      .memwrite_o (memwrite_o),
      .illegal_o  (illegal_o),
      .failcnt_o  (failcnt_o)
   );

   // Strobes packed as {valid, pcsrc, regwrite, memwrite, illegal}.
   typedef struct {
      logic          en, stall, flush;
      logic [3:0]    cond, alu;
      logic [1:0]    fw;
      logic          pcs, regw, memw, nw;
      logic          x_condex;
      logic [4:0]    x_str;
      logic [3:0]    x_flags;
      logic [CW-1:0] x_cnt;
   } vec_t;

   typedef struct {
      int            idx;
      logic [4:0]    str;
      logic [3:0]    flags;
      logic [CW-1:0] cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];

   function automatic vec_t mk(input logic [2:0] ctl, input logic [3:0] cond,
                               input logic [3:0] alu, input logic [1:0] fw,
                               input logic [3:0] req, input logic xc,
                               input logic [4:0] xs, input logic [3:0] xf,
                               input logic [CW-1:0] xn);
      vec_t v;
      {v.en, v.stall, v.flush} = ctl;
      v.cond = cond; v.alu = alu; v.fw = fw;
      {v.pcs, v.regw, v.memw, v.nw} = req;
      v.x_condex = xc; v.x_str = xs; v.x_flags = xf; v.x_cnt = xn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      en_i = 0; stall_i = 0; flush_i = 0; cond_i = 4'hE; aluflags_i = 0;
      flagw_i = 0; pcs_i = 0; regw_i = 0; memw_i = 0; nowrite_i = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      // ctl={en,stall,flush}, req={pcs,regw,memw,nowrite}, strobes={v,p,r,m,i}
      vecs.push_back(mk(3'b100, 4'hE, 4'b0100, 2'b11, 4'b0100, 1, 5'b10100, 4'b0100, 0)); // AL sets Z
      vecs.push_back(mk(3'b100, 4'h0, 4'b0000, 2'b00, 4'b1000, 1, 5'b11000, 4'b0100, 0)); // EQ pass
      vecs.push_back(mk(3'b100, 4'hE, 4'b0000, 2'b11, 4'b0110, 1, 5'b10110, 4'b0000, 0)); // clear flags
      vecs.push_back(mk(3'b100, 4'h0, 4'b0000, 2'b00, 4'b1000, 0, 5'b10000, 4'b0000, 1)); // EQ fail
      vecs.push_back(mk(3'b100, 4'hE, 4'b0100, 2'b11, 4'b0101, 1, 5'b10000, 4'b0100, 1)); // CMP
      vecs.push_back(mk(3'b100, 4'h0, 4'b0000, 2'b00, 4'b1000, 1, 5'b11000, 4'b0100, 1)); // BEQ no bubble
      vecs.push_back(mk(3'b100, 4'hE, 4'b1001, 2'b11, 4'b0000, 1, 5'b10000, 4'b1001, 1));
      vecs.push_back(mk(3'b100, 4'hA, 4'b0000, 2'b00, 4'b1000, 1, 5'b11000, 4'b1001, 1)); // GE
      vecs.push_back(mk(3'b100, 4'hB, 4'b0000, 2'b00, 4'b1000, 0, 5'b10000, 4'b1001, 2)); // LT
      vecs.push_back(mk(3'b100, 4'hC, 4'b0000, 2'b00, 4'b1000, 1, 5'b11000, 4'b1001, 2)); // GT
      vecs.push_back(mk(3'b100, 4'hD, 4'b0000, 2'b00, 4'b0010, 0, 5'b10000, 4'b1001, 3)); // LE
      vecs.push_back(mk(3'b100, 4'hE, 4'b0010, 2'b11, 4'b0000, 1, 5'b10000, 4'b0010, 3));
      vecs.push_back(mk(3'b100, 4'h8, 4'b0000, 2'b00, 4'b0100, 1, 5'b10100, 4'b0010, 3)); // HI pass
      vecs.push_back(mk(3'b100, 4'hE, 4'b0110, 2'b11, 4'b0000, 1, 5'b10000, 4'b0110, 3));
      vecs.push_back(mk(3'b100, 4'h8, 4'b0000, 2'b00, 4'b0100, 0, 5'b10000, 4'b0110, 3)); // HI fail, saturate
      vecs.push_back(mk(3'b100, 4'h9, 4'b0000, 2'b00, 4'b0100, 1, 5'b10100, 4'b0110, 3)); // LS
      vecs.push_back(mk(3'b100, 4'hE, 4'b1111, 2'b11, 4'b0000, 1, 5'b10000, 4'b1111, 3));
      vecs.push_back(mk(3'b000, 4'h1, 4'b0000, 2'b00, 4'b0000, 0, 5'b00000, 4'b1111, 3)); // NE
      vecs.push_back(mk(3'b000, 4'h2, 4'b0000, 2'b00, 4'b0000, 1, 5'b00000, 4'b1111, 3)); // CS
      vecs.push_back(mk(3'b000, 4'h3, 4'b0000, 2'b00, 4'b0000, 0, 5'b00000, 4'b1111, 3)); // CC
      vecs.push_back(mk(3'b000, 4'h4, 4'b0000, 2'b00, 4'b0000, 1, 5'b00000, 4'b1111, 3)); // MI
      vecs.push_back(mk(3'b000, 4'h5, 4'b0000, 2'b00, 4'b0000, 0, 5'b00000, 4'b1111, 3)); // PL
      vecs.push_back(mk(3'b000, 4'h6, 4'b0000, 2'b00, 4'b0000, 1, 5'b00000, 4'b1111, 3)); // VS
      vecs.push_back(mk(3'b000, 4'h7, 4'b0000, 2'b00, 4'b0000, 0, 5'b00000, 4'b1111, 3)); // VC
      vecs.push_back(mk(3'b100, 4'hE, 4'b0000, 2'b01, 4'b0110, 1, 5'b10110, 4'b1100, 3)); // partial C,V
      vecs.push_back(mk(3'b110, 4'hE, 4'b0000, 2'b11, 4'b1000, 1, 5'b10110, 4'b1100, 3)); // stall holds
      vecs.push_back(mk(3'b101, 4'hE, 4'b0000, 2'b11, 4'b1110, 1, 5'b00000, 4'b1100, 3)); // flush
      vecs.push_back(mk(3'b100, 4'hE, 4'b0011, 2'b10, 4'b0000, 1, 5'b10000, 4'b0000, 3)); // partial N,Z
      vecs.push_back(mk(3'b100, 4'hF, 4'b1111, 2'b11, 4'b0010, 0, 5'b10001, 4'b0000, 3)); // illegal
      vecs.push_back(mk(3'b000, 4'hE, 4'b1111, 2'b11, 4'b1110, 1, 5'b00000, 4'b0000, 3)); // en=0

      idle_inputs();
      reset_n = 0;
      #12;
      chk("reset_flags", {4'h0, flags_o}, 8'h00);
      chk("reset_strobes", {3'b0, valid_o, pcsrc_o, regwrite_o, memwrite_o, illegal_o}, 8'h00);
      chk("reset_cnt", {{(8-CW){1'b0}}, failcnt_o}, 8'h00);
      @(negedge clk);
      reset_n = 1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         en_i = vecs[i].en; stall_i = vecs[i].stall; flush_i = vecs[i].flush;
         cond_i = vecs[i].cond; aluflags_i = vecs[i].alu; flagw_i = vecs[i].fw;
         pcs_i = vecs[i].pcs; regw_i = vecs[i].regw; memw_i = vecs[i].memw;
         nowrite_i = vecs[i].nw;
         #1;
         chk($sformatf("condex[%0d]", i), {7'b0, condex_o}, {7'b0, vecs[i].x_condex});
         sbq.push_back('{idx: i, str: vecs[i].x_str, flags: vecs[i].x_flags, cnt: vecs[i].x_cnt});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         chk($sformatf("strobes[%0d]", e.idx),
             {3'b0, valid_o, pcsrc_o, regwrite_o, memwrite_o, illegal_o}, {3'b0, e.str});
         chk($sformatf("flags[%0d]", e.idx), {4'h0, flags_o}, {4'h0, e.flags});
         chk($sformatf("failcnt[%0d]", e.idx), {{(8-CW){1'b0}}, failcnt_o},
             {{(8-CW){1'b0}}, e.cnt});
      end

      // Asynchronous reset between edges clears an in-flight strobe at once.
      @(negedge clk);
      en_i = 1; stall_i = 0; flush_i = 0; cond_i = 4'hE; aluflags_i = 4'b1010;
      flagw_i = 2'b11; pcs_i = 1; regw_i = 1; memw_i = 1; nowrite_i = 0;
      @(posedge clk);
      #1;
      chk("pre_reset_pcsrc", {7'b0, pcsrc_o}, 8'h01);
      chk("pre_reset_flags", {4'h0, flags_o}, 8'h0A);
      #2;
      reset_n = 0;
      #1;
      chk("async_reset_strobes", {3'b0, valid_o, pcsrc_o, regwrite_o, memwrite_o, illegal_o}, 8'h00);
      chk("async_reset_flags", {4'h0, flags_o}, 8'h00);
      chk("async_reset_cnt", {{(8-CW){1'b0}}, failcnt_o}, 8'h00);
      idle_inputs();
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
